gate_bist_ctrl: RTL
===================

Name: gate_bist_ctrl

Overview:
Built-in self-test controller for the 3-input XNOR gate datapath. On a start request it applies all 8 input patterns in ascending {a,b,c} order and waits a programmable settle time per pattern. It then samples the gate output and compares it against a parameterised truth table. Results are reported as a pass flag, error count, first failing index and the captured response vector. It sits between system control logic and the gate instance and owns the gate's input pins during a test.

Parameters:
SETTLE_CYC, 1, extra cycles each pattern is held before sampling; legal range 0..15.
TRUTH_TABLE, 8'h69, expected output; bit k = expected dout for pattern k = {a,b,c}. Default is 3-input XNOR.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  test request, sampled in IDLE only
abort  input  1  cancel running test
dut_dout  input  1  gate output under test
dut_a  output  1  gate input a (pattern bit 2)
dut_b  output  1  gate input b (pattern bit 1)
dut_c  output  1  gate input c (pattern bit 0)
busy  output  1  high while a test is running
done  output  1  one-cycle pulse at test completion
pass  output  1  1 = all 8 samples matched; held until next start
err_cnt  output  4  number of mismatches, 0..8
fail_idx  output  3  first failing pattern index; 0 if err_cnt==0
resp  output  8  captured response; bit k = dout sampled for pattern k

Behaviour:
- Reset (async, rst_n low): state=IDLE. dut_a/b/c=0, busy=0, done=0, pass=0, err_cnt=0, fail_idx=0, resp=0. Pattern index idx=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE: dut_*=0 and busy=0. On start=1 and abort=0, go to SETTLE with idx=0 and counter=0. Clear err_cnt, fail_idx, resp and pass on the same edge, and drive pattern 0 from the next cycle.
- SETTLE: drive {dut_a,dut_b,dut_c}=idx with busy=1. Increment the counter each cycle. Go to SAMPLE once the counter reaches SETTLE_CYC. With SETTLE_CYC=0, SETTLE lasts 1 cycle.
- SAMPLE: pattern is still driven. On the clock edge leaving SAMPLE:
  - capture dut_dout into resp[idx];
  - on mismatch against TRUTH_TABLE[idx], increment err_cnt;
  - on the first mismatch, load fail_idx with idx.
  - If idx==7, go to DONE. Otherwise increment idx, clear the counter and return to SETTLE.
- Each pattern therefore occupies SETTLE_CYC+2 cycles.
- DONE: one cycle long. done=1, busy=0, dut_*=0. pass=(err_cnt==0), computed after the final sample's update. Next state is IDLE.
- Latency: start is sampled at edge 0 and done is high during cycle 1+8*(SETTLE_CYC+2). With the default this is cycle 25.
- Result hold: pass, err_cnt, fail_idx and resp are held through IDLE until the next accepted start.
- start while busy or in DONE: ignored, with no restart.
- abort in SETTLE or SAMPLE: next state is IDLE and dut_*=0.
  - No done pulse is produced, and pass=0.
  - err_cnt, fail_idx and resp keep their partial values.
  - The sample in progress is discarded.
- abort in IDLE or DONE: no effect. If start and abort are both high in IDLE, abort wins and no test starts.
- Reset during a test: immediate return to reset values, with no done pulse.
- err_cnt never exceeds 8; no wrap is possible.

Test Plan:
- Ideal XNOR model on dut_*, default parameters, pulse start. Required: busy high cycles 1..24, done pulse at cycle 25, pass=1, err_cnt=0, fail_idx=0, resp=8'h69. Patterns 0..7 each held 3 cycles in order.
- Stuck-at-0 gate model (dut_dout=0). Required: pass=0, err_cnt=4, fail_idx=0, resp=8'h00. A stuck-at-1 model gives err_cnt=4, fail_idx=1, resp=8'hFF.
- XOR gate model instead of XNOR. Required: err_cnt=8, fail_idx=0, resp=8'h96, pass=0.
- SETTLE_CYC=0 with ideal model. Required: done at cycle 17, each pattern held 2 cycles, pass=1.
- Assert abort while idx=3 in SETTLE. Required: IDLE next cycle, dut_*=0, busy=0, no done pulse, pass=0, resp[2:0]=3'b001. A new start then runs to completion with pass=1.
- start pulsed again at cycle 10 mid-test: ignored and timing unchanged. start+abort together in IDLE: nothing starts. rst_n low at cycle 12: all outputs 0 asynchronously, no done pulse.

Source files
------------

// File: rtl/gate_bist_ctrl_if.sv
// Control, status and gate-pin bundle between system logic, the BIST controller and the gate.
// The controller side uses the slave modport; the system/gate side uses master.
interface gate_bist_ctrl_if;
    logic       start;
    logic       abort;
    logic       dut_dout;
    logic       dut_a;
    logic       dut_b;
    logic       dut_c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
    logic [2:0] fail_idx;
    logic [7:0] resp;

    modport master (
        output start, abort, dut_dout,
        input  dut_a, dut_b, dut_c, busy, done, pass, err_cnt, fail_idx, resp
    );

    modport slave (
        input  start, abort, dut_dout,
        output dut_a, dut_b, dut_c, busy, done, pass, err_cnt, fail_idx, resp
    );
endinterface

// File: rtl/gate_bist_ctrl.sv
// BIST controller for the 3-input gate: walks all 8 patterns, holds each for a settle
// time, samples the gate output and scores it against TRUTH_TABLE.
module gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYC  = 1,
    parameter logic [7:0]  TRUTH_TABLE = 8'h69
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_bist_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYC);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       mismatch;
    logic [3:0] err_next;

    // Score of the sample being taken this cycle, used both for err_cnt and the final pass flag.
    assign mismatch = (bus.dut_dout != TRUTH_TABLE[idx]);
    assign err_next = bus.err_cnt + {3'b000, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= 3'd0;
            cnt          <= 4'd0;
            bus.dut_a    <= 1'b0;
            bus.dut_b    <= 1'b0;
            bus.dut_c    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.pass     <= 1'b0;
            bus.err_cnt  <= 4'd0;
            bus.fail_idx <= 3'd0;
            bus.resp     <= 8'd0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state                           <= SETTLE;
                        idx                             <= 3'd0;
                        cnt                             <= 4'd0;
                        bus.busy                        <= 1'b1;
                        {bus.dut_a, bus.dut_b, bus.dut_c} <= 3'd0;
                        bus.pass                        <= 1'b0;
                        bus.err_cnt                     <= 4'd0;
                        bus.fail_idx                    <= 3'd0;
                        bus.resp                        <= 8'd0;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        state                           <= IDLE;
                        bus.busy                        <= 1'b0;
                        bus.pass                        <= 1'b0;
                        {bus.dut_a, bus.dut_b, bus.dut_c} <= 3'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (cnt == SETTLE_LIM) state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    // An aborted sample is dropped entirely; partial results stay visible.
                    if (bus.abort) begin
                        state                           <= IDLE;
                        bus.busy                        <= 1'b0;
                        bus.pass                        <= 1'b0;
                        {bus.dut_a, bus.dut_b, bus.dut_c} <= 3'd0;
                    end else begin
                        bus.resp[idx] <= bus.dut_dout;
                        if (mismatch) begin
                            bus.err_cnt <= err_next;
                            if (bus.err_cnt == 4'd0) bus.fail_idx <= idx;
                        end
                        if (idx == 3'd7) begin
                            state                           <= DONE;
                            bus.busy                        <= 1'b0;
                            bus.done                        <= 1'b1;
                            bus.pass                        <= (err_next == 4'd0);
                            {bus.dut_a, bus.dut_b, bus.dut_c} <= 3'd0;
                        end else begin
                            state                           <= SETTLE;
                            idx                             <= idx + 3'd1;
                            cnt                             <= 4'd0;
                            {bus.dut_a, bus.dut_b, bus.dut_c} <= idx + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
